fft_spi_arbiter: RTL and testbench



---
 rtl/fft_spi_pkg.sv | 21 ++
 rtl/fft_spi_rr_pick.sv | 34 +++
 rtl/fft_spi_arbiter.sv | 165 ++++++++++++++++
 tb/tb_fft_spi_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_spi_pkg.sv
// Shared encodings for the FFT/debug SPI byte-link arbiter.
package fft_spi_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_BYTE = 3'd1,
        SEND      = 3'd2,
        GAP       = 3'd3,
        DRAIN     = 3'd4,
        HDR       = 3'd5
    } state_t;

    // Wide enough for the largest supported requester count (16).
    localparam int IDX_W = 4;

    // Header bytes carry their marker flag in the MSB of the byte.
    function automatic int hdr_flag_pos(input int byte_w);
        return byte_w - 1;
    endfunction

endpackage

// File: rtl/fft_spi_rr_pick.sv
// Combinational round-robin picker: first request above the pointer, with wrap.
module fft_spi_rr_pick
    import fft_spi_pkg::*;
#(
    parameter int NUM_REQ = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_onehot,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    logic w_found;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        w_found  = 1'b0;
        // Pass 0 scans indices above the pointer, pass 1 wraps to the rest.
        for (int pass = 0; pass < 2; pass++) begin
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!w_found && i_req[j] && ((pass == 0) == (j > int'(i_ptr)))) begin
                    w_found     = 1'b1;
                    o_onehot[j] = 1'b1;
                    o_idx       = IDX_W'(j);
                end
            end
        end
    end

    assign o_any = |i_req;

endmodule

// File: rtl/fft_spi_arbiter.sv
// Packet-locked round-robin sharing of one SPI byte transmitter.
// Define FFT_SPI_ARB_HDR_EN to prefix every packet with a {1, owner} header byte.
module fft_spi_arbiter
    import fft_spi_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int BYTE_W  = 8
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_REQ-1:0]        i_req_valid,
    input  logic [NUM_REQ*BYTE_W-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]        i_req_last,
    output logic [NUM_REQ-1:0]        o_req_ready,
    output logic [BYTE_W-1:0]         o_tx_byte,
    output logic                      o_tx_dv,
    input  logic                      i_tx_ready,
    output logic [NUM_REQ-1:0]        o_grant,
    output logic                      o_busy
);

    // state     | meaning
    // IDLE      | no owner; arbitrate among valid requesters
    // HDR       | wait for master ready, then load header byte
    // WAIT_BYTE | owner may hand over a byte while master is ready
    // SEND      | one-cycle tx_dv pulse
    // GAP       | master is still raising busy; ready ignored
    // DRAIN     | wait for master ready; release grant after last byte

    state_t              r_state;
    state_t              w_next_state;
    logic [NUM_REQ-1:0]  r_grant;
    logic [IDX_W-1:0]    r_owner;
    logic [IDX_W-1:0]    r_ptr;
    logic [BYTE_W-1:0]   r_tx_byte;
    logic                r_last;

    logic [NUM_REQ-1:0]  w_pick_onehot;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    logic                w_sel_valid;
    logic                w_sel_last;
    logic [BYTE_W-1:0]   w_sel_data;
    logic                w_xfer;
    logic                w_start;
    logic                w_release;

    fft_spi_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .i_req    (i_req_valid),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (r_grant[j]) begin
                w_sel_valid = i_req_valid[j];
                w_sel_last  = i_req_last[j];
                w_sel_data  = i_req_data[j*BYTE_W +: BYTE_W];
            end
        end
    end

    assign w_xfer    = (r_state == WAIT_BYTE) && i_tx_ready && w_sel_valid;
    assign w_start   = (r_state == IDLE) && w_pick_any;
    assign w_release = (r_state == DRAIN) && i_tx_ready && r_last;

`ifdef FFT_SPI_ARB_HDR_EN
    localparam int HDR_FLAG = hdr_flag_pos(BYTE_W);
    logic [BYTE_W-1:0] w_hdr_byte;
    logic              w_hdr_load;

    always_comb begin
        w_hdr_byte           = BYTE_W'(r_owner);
        w_hdr_byte[HDR_FLAG] = 1'b1;
    end

    assign w_hdr_load = (r_state == HDR) && i_tx_ready;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_pick_any) begin
`ifdef FFT_SPI_ARB_HDR_EN
                    w_next_state = HDR;
`else
                    w_next_state = WAIT_BYTE;
`endif
                end
            end
`ifdef FFT_SPI_ARB_HDR_EN
            HDR:       if (i_tx_ready) w_next_state = SEND;
`endif
            WAIT_BYTE: if (w_xfer) w_next_state = SEND;
            SEND:      w_next_state = GAP;
            GAP:       w_next_state = DRAIN;
            DRAIN: begin
                if (i_tx_ready) begin
                    w_next_state = r_last ? IDLE : WAIT_BYTE;
                end
            end
            default:   w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_grant   <= '0;
            r_owner   <= '0;
            r_ptr     <= IDX_W'(NUM_REQ - 1);
            r_tx_byte <= '0;
            r_last    <= 1'b0;
        end else begin
            if (w_start) begin
                r_grant <= w_pick_onehot;
                r_owner <= w_pick_idx;
            end
            if (w_xfer) begin
                r_tx_byte <= w_sel_data;
                r_last    <= w_sel_last;
            end
`ifdef FFT_SPI_ARB_HDR_EN
            if (w_hdr_load) begin
                r_tx_byte <= w_hdr_byte;
                r_last    <= 1'b0;
            end
`endif
            // Pointer parks on the finished owner so it loses the next tie.
            if (w_release) begin
                r_grant <= '0;
                r_ptr   <= r_owner;
            end
        end
    end

    always_comb begin
        o_req_ready = '0;
        if (r_state == WAIT_BYTE) begin
            o_req_ready = r_grant & {NUM_REQ{i_tx_ready}};
        end
        o_tx_dv = (r_state == SEND);
        o_busy  = (r_state != IDLE);
    end

    assign o_tx_byte = r_tx_byte;
    assign o_grant   = r_grant;

endmodule

// File: tb/tb_fft_spi_arbiter.sv
// Directed bench for fft_spi_arbiter with a simple SPI master and requester models.
module tb_fft_spi_arbiter;

    localparam int NUM_REQ = 2;
    localparam int BYTE_W  = 8;
    localparam int GAP_LEN = 16;
`ifdef FFT_SPI_ARB_HDR_EN
    localparam bit HDR_ON = 1'b1;
`else
    localparam bit HDR_ON = 1'b0;
`endif

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        i_req_valid;
    logic [NUM_REQ*BYTE_W-1:0] i_req_data;
    logic [NUM_REQ-1:0]        i_req_last;
    logic [NUM_REQ-1:0]        o_req_ready;
    logic [BYTE_W-1:0]         o_tx_byte;
    logic                      o_tx_dv;
    logic                      i_tx_ready;
    logic [NUM_REQ-1:0]        o_grant;
    logic                      o_busy;

    always #5 clk = ~clk;

    fft_spi_arbiter #(
        .NUM_REQ (NUM_REQ),
        .BYTE_W  (BYTE_W)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_tx_byte   (o_tx_byte),
        .o_tx_dv     (o_tx_dv),
        .i_tx_ready  (i_tx_ready),
        .o_grant     (o_grant),
        .o_busy      (o_busy)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    logic [8:0] q0[$];
    logic [8:0] q1[$];
    logic [7:0] txq[$];
    logic [7:0] expq[$];
    logic [1:0] glog[$];
    logic [1:0] en;
    logic [1:0] hs;
    logic [1:0] prev_grant;
    logic [1:0] gexp;
    logic       hold;
    logic       dv_s;
    logic       gtrack;
    int         cnt;
    int         dv_cnt;
    int         gbad;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic drive();
        i_req_valid = '0;
        i_req_last  = '0;
        i_req_data  = '0;
        if (en[0] && q0.size() > 0) begin
            i_req_valid[0]  = 1'b1;
            i_req_last[0]   = q0[0][8];
            i_req_data[7:0] = q0[0][7:0];
        end
        if (en[1] && q1.size() > 0) begin
            i_req_valid[1]   = 1'b1;
            i_req_last[1]    = q1[0][8];
            i_req_data[15:8] = q1[0][7:0];
        end
        i_tx_ready = (cnt == 0) && !hold;
    endtask

    // Inputs move 1 unit after the rising edge; outputs are sampled on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        if (hs[0] && q0.size() > 0) void'(q0.pop_front());
        if (hs[1] && q1.size() > 0) void'(q1.pop_front());
        if (dv_s) cnt = GAP_LEN;
        else if (cnt > 0) cnt--;
        drive();
        @(negedge clk);
        hs   = i_req_valid & o_req_ready;
        dv_s = o_tx_dv;
        if (o_tx_dv) begin
            txq.push_back(o_tx_byte);
            dv_cnt++;
        end
        if (o_grant != '0 && prev_grant == '0) glog.push_back(o_grant);
        prev_grant = o_grant;
        if (gtrack && o_busy && o_grant !== gexp) gbad++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = '0;
        q0.delete();
        q1.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic clr();
        txq.delete();
        expq.delete();
        glog.delete();
        dv_cnt = 0;
    endtask

    task automatic exp_hdr(input int r);
        if (HDR_ON) expq.push_back(8'h80 | 8'(r));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((o_busy || q0.size() > 0 || q1.size() > 0) && n < budget);
        chk({tag, "_done"}, 32'(o_busy || q0.size() > 0 || q1.size() > 0), 32'd0);
    endtask

    task automatic chk_stream(input string tag);
        chk({tag, "_dv_count"}, dv_cnt, expq.size());
        for (int i = 0; i < expq.size(); i++) begin
            chk($sformatf("%s_byte[%0d]", tag, i),
                (i < txq.size()) ? 32'(txq[i]) : 32'hxxxx_xxxx, 32'(expq[i]));
        end
    endtask

    task automatic chk_glog(input string tag, input logic [1:0] g0, input logic [1:0] g1);
        chk({tag, "_grant_count"}, glog.size(), 2);
        chk({tag, "_grant[0]"}, (glog.size() > 0) ? 32'(glog[0]) : 32'hxxxx_xxxx, 32'(g0));
        chk({tag, "_grant[1]"}, (glog.size() > 1) ? 32'(glog[1]) : 32'hxxxx_xxxx, 32'(g1));
    endtask

    initial begin
        int n;
        int rdy1;
        int base;
        int bad;

        rst = 1'b1; en = '0; hold = 1'b0; cnt = 0; hs = '0; dv_s = 1'b0;
        prev_grant = '0; gexp = '0; gtrack = 1'b0; gbad = 0; dv_cnt = 0;
        drive();
        repeat (3) tick();
        chk("rst_grant",     32'(o_grant),     32'd0);
        chk("rst_busy",      32'(o_busy),      32'd0);
        chk("rst_tx_dv",     32'(o_tx_dv),     32'd0);
        chk("rst_tx_byte",   32'(o_tx_byte),   32'd0);
        chk("rst_req_ready", 32'(o_req_ready), 32'd0);
        rst = 1'b0;

        // Single requester, three-byte packet.
        clr();
        q0.push_back({1'b0, 8'h11}); q0.push_back({1'b0, 8'h22}); q0.push_back({1'b1, 8'h33});
        en = 2'b01;
        tick();
        chk("t1_grant_before_arb", 32'(o_grant), 32'd0);
        tick();
        chk("t1_grant_after_arb", 32'(o_grant), 32'd1);
        chk("t1_first_ready", 32'(o_req_ready), HDR_ON ? 32'd0 : 32'd1);
        gexp = 2'b01; gtrack = 1'b1; gbad = 0;
        wait_idle("t1", 300);
        gtrack = 1'b0;
        chk("t1_grant_held", gbad, 0);
        chk("t1_grant_end", 32'(o_grant), 32'd0);
        chk("t1_busy_end", 32'(o_busy), 32'd0);
        exp_hdr(0); expq.push_back(8'h11); expq.push_back(8'h22); expq.push_back(8'h33);
        chk_stream("t1");

        // Both requesters, two packets each: fair alternation 0,1,0,1.
        do_reset();
        clr();
        q0.push_back({1'b0, 8'h01}); q0.push_back({1'b1, 8'h02});
        q0.push_back({1'b0, 8'h03}); q0.push_back({1'b1, 8'h04});
        q1.push_back({1'b0, 8'hA1}); q1.push_back({1'b1, 8'hA2});
        q1.push_back({1'b0, 8'hA3}); q1.push_back({1'b1, 8'hA4});
        en = 2'b11;
        wait_idle("t2", 800);
        chk("t2_grant_count", glog.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t2_grant[%0d]", i),
                (i < glog.size()) ? 32'(glog[i]) : 32'hxxxx_xxxx, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        exp_hdr(0); expq.push_back(8'h01); expq.push_back(8'h02);
        exp_hdr(1); expq.push_back(8'hA1); expq.push_back(8'hA2);
        exp_hdr(0); expq.push_back(8'h03); expq.push_back(8'h04);
        exp_hdr(1); expq.push_back(8'hA3); expq.push_back(8'hA4);
        chk_stream("t2");

        // Owner stalls mid-packet while requester 1 waits.
        clr();
        q0.push_back({1'b0, 8'h31}); q0.push_back({1'b0, 8'h32}); q0.push_back({1'b1, 8'h33});
        q1.push_back({1'b1, 8'h41});
        en = 2'b11;
        n = 0;
        while (q0.size() == 3 && n < 200) begin
            tick();
            n++;
        end
        chk("t3_first_byte_taken", q0.size(), 2);
        en = 2'b10;
        base = dv_cnt;
        rdy1 = 0;
        repeat (20) begin
            tick();
            if (o_req_ready[1]) rdy1++;
        end
        chk("t3_stall_ready1", rdy1, 0);
        chk("t3_stall_dv", dv_cnt - base, 0);
        chk("t3_stall_grant", 32'(o_grant), 32'd1);
        chk("t3_stall_q1", q1.size(), 1);
        en = 2'b11;
        wait_idle("t3", 300);
        chk_glog("t3", 2'b01, 2'b10);
        exp_hdr(0); expq.push_back(8'h31); expq.push_back(8'h32); expq.push_back(8'h33);
        exp_hdr(1); expq.push_back(8'h41);
        chk_stream("t3");

        // Master held busy while the owner has a byte waiting.
        clr();
        hold = 1'b1;
        q0.push_back({1'b1, 8'h55});
        en = 2'b01;
        tick();
        bad = 0;
        repeat (10) begin
            tick();
            if (o_req_ready != '0) bad++;
        end
        chk("t4_hold_ready", bad, 0);
        chk("t4_hold_q0", q0.size(), 1);
        chk("t4_hold_dv", dv_cnt, 0);
        chk("t4_hold_grant", 32'(o_grant), 32'd1);
        hold = 1'b0;
        tick();
        n = 1;
        while (!o_req_ready[0] && n < 100) begin
            tick();
            n++;
        end
        chk("t4_ready_up", 32'(o_req_ready), 32'd1);
        base = dv_cnt;
        tick();
        chk("t4_dv_next", 32'(o_tx_dv), 32'd1);
        chk("t4_byte_next", 32'(o_tx_byte), 32'h55);
        chk("t4_dv_count_next", dv_cnt - base, 1);
        wait_idle("t4", 200);
        exp_hdr(0); expq.push_back(8'h55);
        chk_stream("t4");

        // Reset during DRAIN of byte 2 of 4.
        clr();
        q1.push_back({1'b0, 8'h61}); q1.push_back({1'b0, 8'h62});
        q1.push_back({1'b0, 8'h63}); q1.push_back({1'b1, 8'h64});
        en = 2'b10;
        n = 0;
        while (q1.size() > 2 && n < 300) begin
            tick();
            n++;
        end
        chk("t5_two_taken", q1.size(), 2);
        tick();
        tick();
        chk("t5_pre_busy", 32'(o_busy), 32'd1);
        chk("t5_pre_grant", 32'(o_grant), 32'd2);
        rst = 1'b1;
        en = '0;
        q1.delete();
        tick();
        chk("t5_rst_grant", 32'(o_grant), 32'd0);
        chk("t5_rst_dv", 32'(o_tx_dv), 32'd0);
        chk("t5_rst_busy", 32'(o_busy), 32'd0);
        chk("t5_rst_ready", 32'(o_req_ready), 32'd0);
        rst = 1'b0;
        n = 0;
        while (cnt > 0 && n < 50) begin
            tick();
            n++;
        end
        clr();
        q0.push_back({1'b1, 8'h71});
        q1.push_back({1'b1, 8'h72});
        en = 2'b11;
        wait_idle("t5", 300);
        chk_glog("t5", 2'b01, 2'b10);
        exp_hdr(0); expq.push_back(8'h71);
        exp_hdr(1); expq.push_back(8'h72);
        chk_stream("t5");

`ifdef FFT_SPI_ARB_HDR_EN
        // Header prefix on a single-byte packet from requester 1.
        do_reset();
        clr();
        q1.push_back({1'b1, 8'h5A});
        en = 2'b10;
        wait_idle("t6", 200);
        expq.push_back(8'h81); expq.push_back(8'h5A);
        chk_stream("t6");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
